// File: rtl/camera_downsampler.sv
// Camera capture: RGB565 byte stream (two bytes/pixel, high first) to RGB332 framebuffer writes.
// Writes are registered one cycle after the low byte; lines/columns past the screen are converted but dropped.
module camera_downsampler #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144
) (
  input  logic       CLK,
  input  logic       RESET_NEG,
  input  logic [7:0] CAM_DATA,
  input  logic       CAM_HREF,
  input  logic       CAM_VSYNC,
  output logic [7:0] PIXEL_OUT,
  output logic       W_EN,
  output logic [7:0] X_ADDR,
  output logic [7:0] Y_ADDR,
  output logic       FRAME_DONE
);

  typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, BYTE_HI, BYTE_LO} state_t;

  localparam logic [8:0] W_LIM = SCREEN_WIDTH[8:0];
  localparam logic [8:0] H_LIM = SCREEN_HEIGHT[8:0];

  state_t     state_q, state_d;
  logic [8:0] col_q, col_d, row_q, row_d;
  logic [5:0] hi_q, hi_d;
  logic [7:0] pixel_q, pixel_d, x_q, x_d, y_q, y_d;
  logic       w_en_q, w_en_d, frame_done_q, frame_done_d;
  logic       line_seen_q, line_seen_d;
  logic       href_prev_q, href_prev_d, vsync_prev_q, vsync_prev_d;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    hi_d         = hi_q;
    pixel_d      = pixel_q;
    x_d          = x_q;
    y_d          = y_q;
    w_en_d       = 1'b0;
    frame_done_d = 1'b0;
    line_seen_d  = line_seen_q;
    href_prev_d  = CAM_HREF;
    vsync_prev_d = CAM_VSYNC;

    if (CAM_VSYNC && !vsync_prev_q && line_seen_q) begin
      frame_done_d = 1'b1;
      line_seen_d  = 1'b0;
    end

    if (state_q == WAIT_FRAME) begin
      col_d = '0;
      row_d = '0;
      if (!CAM_VSYNC) state_d = WAIT_LINE;
    end else if (CAM_VSYNC) begin
      state_d = WAIT_FRAME;
      col_d   = '0;
      row_d   = '0;
    end else if (state_q == WAIT_LINE) begin
      // A rising HREF is required so a line already running at reset release is skipped.
      if (CAM_HREF && !href_prev_q) begin
        hi_d    = {CAM_DATA[7:5], CAM_DATA[2:0]};
        state_d = BYTE_LO;
      end
    end else if (!CAM_HREF) begin
      state_d     = WAIT_LINE;
      col_d       = '0;
      row_d       = (row_q < H_LIM) ? row_q + 9'd1 : row_q;
      line_seen_d = 1'b1;
    end else if (state_q == BYTE_LO) begin
      if (col_q < W_LIM && row_q < H_LIM) begin
        w_en_d  = 1'b1;
        pixel_d = {hi_q, CAM_DATA[4:3]};
        x_d     = col_q[7:0];
        y_d     = row_q[7:0];
      end
      col_d   = (col_q < W_LIM) ? col_q + 9'd1 : col_q;
      state_d = BYTE_HI;
    end else begin
      hi_d    = {CAM_DATA[7:5], CAM_DATA[2:0]};
      state_d = BYTE_LO;
    end
  end

  always_ff @(posedge CLK or negedge RESET_NEG) begin
    if (!RESET_NEG) begin
      state_q      <= WAIT_FRAME;
      col_q        <= '0;
      row_q        <= '0;
      hi_q         <= '0;
      pixel_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      w_en_q       <= 1'b0;
      frame_done_q <= 1'b0;
      line_seen_q  <= 1'b0;
      href_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hi_q         <= hi_d;
      pixel_q      <= pixel_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_en_q       <= w_en_d;
      frame_done_q <= frame_done_d;
      line_seen_q  <= line_seen_d;
      href_prev_q  <= href_prev_d;
      vsync_prev_q <= vsync_prev_d;
    end
  end

  assign PIXEL_OUT  = pixel_q;
  assign W_EN       = w_en_q;
  assign X_ADDR     = x_q;
  assign Y_ADDR     = y_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_camera_downsampler.sv
// Bench for camera_downsampler: random and directed camera traffic against a line/pixel-level model.
module tb_camera_downsampler;
  localparam int W = 176;
  localparam int H = 144;

  logic       CLK = 1'b0;
  logic       RESET_NEG = 1'b0;
  logic [7:0] CAM_DATA = 8'h00;
  logic       CAM_HREF = 1'b0;
  logic       CAM_VSYNC = 1'b1;
  logic [7:0] PIXEL_OUT, X_ADDR, Y_ADDR;
  logic       W_EN, FRAME_DONE;

  camera_downsampler #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .CLK(CLK), .RESET_NEG(RESET_NEG), .CAM_DATA(CAM_DATA), .CAM_HREF(CAM_HREF),
    .CAM_VSYNC(CAM_VSYNC), .PIXEL_OUT(PIXEL_OUT), .W_EN(W_EN), .X_ADDR(X_ADDR),
    .Y_ADDR(Y_ADDR), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  int vectors = 0, miscompares = 0;
  logic [23:0] expq[$];        // {x, y, pixel} in write order
  int row_m = 0, lines_done = 0, exp_fd = 0, fd_cnt = 0, wr_cnt = 0, exp_wr = 0;
  logic [7:0] last_x = 8'h00, last_y = 8'h00;
  logic [23:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rgb332(input logic [7:0] h, input logic [7:0] l);
    return {h[7:5], h[2:0], l[4:3]};
  endfunction

  always @(negedge CLK) begin
    if (!RESET_NEG) begin
      chk("rst_wen", 32'(W_EN), 0);
      chk("rst_x", 32'(X_ADDR), 0);
      chk("rst_y", 32'(Y_ADDR), 0);
      chk("rst_fd", 32'(FRAME_DONE), 0);
      last_x = 8'h00;
      last_y = 8'h00;
    end else begin
      if (FRAME_DONE) fd_cnt++;
      if (W_EN) begin
        wr_cnt++;
        if (expq.size() == 0) begin
          chk("spurious_write", 32'(W_EN), 0);
        end else begin
          mon_e = expq.pop_front();
          chk("pixel", 32'(PIXEL_OUT), 32'(mon_e[7:0]));
          chk("x_addr", 32'(X_ADDR), 32'(mon_e[23:16]));
          chk("y_addr", 32'(Y_ADDR), 32'(mon_e[15:8]));
          last_x = mon_e[23:16];
          last_y = mon_e[15:8];
        end
      end else begin
        chk("x_hold", 32'(X_ADDR), 32'(last_x));
        chk("y_hold", 32'(Y_ADDR), 32'(last_y));
      end
    end
  end

  task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge CLK);
    #2;
    CAM_VSYNC = vs;
    CAM_HREF  = hr;
    CAM_DATA  = d;
  endtask

  // n bytes on one HREF; no_end leaves HREF high so the caller can interrupt the line.
  task automatic send_line(input int n, input bit all_ff, input int gap, input bit no_end);
    logic [7:0] hb, b;
    hb = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = all_ff ? 8'hFF : 8'($urandom);
      if (i % 2 == 0) hb = b;
      else if (i / 2 < W && row_m < H) begin
        expq.push_back({8'(i / 2), 8'(row_m), rgb332(hb, b)});
        exp_wr++;
      end
      cyc(1'b0, 1'b1, b);
    end
    if (!no_end) begin
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 8'h00);
      row_m++;
      lines_done++;
    end
  endtask

  task automatic frame_gap(input int n);
    if (lines_done > 0) exp_fd++;
    lines_done = 0;
    row_m = 0;
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  int w0;

  initial begin
    #1;
    chk("reset_pix", 32'(PIXEL_OUT), 0);
    chk("reset_wen", 32'(W_EN), 0);
    chk("reset_fd", 32'(FRAME_DONE), 0);
    repeat (3) @(posedge CLK);
    #2 RESET_NEG = 1'b1;
    frame_gap(3);

    // Single pixel F8,1F -> E3, written the cycle after the low byte
    cyc(1'b0, 1'b1, 8'hF8);
    cyc(1'b0, 1'b1, 8'h1F);
    expq.push_back({8'd0, 8'd0, 8'hE3});
    exp_wr++;
    chk("wen_not_early", 32'(W_EN), 0);
    cyc(1'b0, 1'b0, 8'h00);
    chk("single_wen", 32'(W_EN), 1);
    chk("single_pix", 32'(PIXEL_OUT), 'hE3);
    cyc(1'b0, 1'b0, 8'h00);
    row_m++;
    lines_done++;

    send_line(5, 1'b0, 2, 1'b0);      // odd line: trailing byte dropped
    send_line(8, 1'b0, 1, 1'b0);
    send_line(360, 1'b0, 2, 1'b0);    // overlong line clipped at W
    send_line(10, 1'b0, 3, 1'b0);
    frame_gap(2);

    for (int f = 0; f < 4; f++) begin
      for (int l = 0; l < int'($urandom_range(1, 6)); l++)
        send_line(($urandom_range(0, 7) == 0) ? 360 : int'($urandom_range(1, 50)),
                  1'b0, int'($urandom_range(1, 3)), 1'b0);
      frame_gap(int'($urandom_range(1, 4)));
    end

    // VSYNC (with HREF still high) after the high byte of pixel 10
    send_line(12, 1'b0, 2, 1'b0);
    send_line(9, 1'b0, 2, 1'b0);
    send_line(21, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 8'hAA);
    exp_fd++;
    lines_done = 0;
    row_m = 0;
    cyc(1'b1, 1'b0, 8'h00);
    chk("vs_fd_pulse", 32'(FRAME_DONE), 1);
    chk("vs_no_write", 32'(W_EN), 0);
    cyc(1'b1, 1'b0, 8'h00);
    chk("vs_fd_one_cycle", 32'(FRAME_DONE), 0);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    send_line(6, 1'b0, 2, 1'b0);

    // Reset for two cycles in the middle of line 3
    send_line(14, 1'b0, 2, 1'b0);
    send_line(14, 1'b0, 2, 1'b0);
    send_line(13, 1'b0, 0, 1'b1);
    @(posedge CLK);
    #2 RESET_NEG = 1'b0;
    #1;
    chk("async_rst_wen", 32'(W_EN), 0);
    chk("async_rst_x", 32'(X_ADDR), 0);
    chk("async_rst_y", 32'(Y_ADDR), 0);
    chk("async_rst_pix", 32'(PIXEL_OUT), 0);
    row_m = 0;
    lines_done = 0;
    cyc(1'b0, 1'b1, 8'($urandom));
    @(posedge CLK);
    #2 RESET_NEG = 1'b1;
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 8'($urandom));
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    send_line(10, 1'b0, 2, 1'b0);

    // Full frame of FF bytes plus two lines beyond the screen
    frame_gap(2);
    w0 = wr_cnt;
    for (int l = 0; l < H + 2; l++) send_line(2 * W, 1'b1, 2, 1'b0);
    chk("full_writes", 32'(wr_cnt - w0), 25344);
    chk("full_last_x", 32'(last_x), 175);
    chk("full_last_y", 32'(last_y), 143);
    frame_gap(3);
    repeat (4) cyc(1'b0, 1'b0, 8'h00);

    chk("queue_drained", 32'(expq.size()), 0);
    chk("total_writes", 32'(wr_cnt), 32'(exp_wr));
    chk("frame_done_count", 32'(fd_cnt), 32'(exp_fd));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/camera_downsampler.md
CAMERA_DOWNSAMPLER -- requirements
Module: camera_downsampler

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 176, pixels written per line; bytes beyond this are dropped.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 144, lines written per frame; lines beyond this are dropped.
REQ-003 SHALL have port CLK  input  1  single clock (camera PCLK); all logic on posedge.
REQ-004 SHALL have port RESET_NEG  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port CAM_DATA  input  8  camera byte, RGB565, two bytes per pixel, high byte first.
REQ-006 SHALL have port CAM_HREF  input  1  high while line bytes are valid.
REQ-007 SHALL have port CAM_VSYNC  input  1  high during vertical blanking / frame start.
REQ-008 SHALL have port PIXEL_OUT  output  8  RGB332 pixel: [7:5] R, [4:2] G, [1:0] B.
REQ-009 SHALL have port W_EN  output  1  one-cycle write strobe for PIXEL_OUT at X_ADDR/Y_ADDR.
REQ-010 SHALL have port X_ADDR  output  8  column of the pixel being written.
REQ-011 SHALL have port Y_ADDR  output  8  row of the pixel being written.
REQ-012 SHALL have port FRAME_DONE  output  1  one-cycle pulse at end of a captured frame.

Function
REQ-013 SHALL implement states WAIT_FRAME, WAIT_LINE, BYTE_HI, BYTE_LO.
REQ-014 WAIT_FRAME: stay while CAM_VSYNC high; go to WAIT_LINE on first cycle with CAM_VSYNC low.
REQ-015 WAIT_LINE: on CAM_HREF high, latch CAM_DATA as high byte and go to BYTE_LO.
REQ-016 BYTE_LO: with CAM_HREF high, form pixel from latched high byte H and CAM_DATA L, go to BYTE_HI.
REQ-017 BYTE_HI: with CAM_HREF high, latch CAM_DATA as high byte, go to BYTE_LO.
REQ-018 Conversion SHALL be R = H[7:5], G = H[2:0], B = L[4:3]; no rounding.
REQ-019 PIXEL_OUT, X_ADDR, Y_ADDR, W_EN SHALL be registered: W_EN high exactly on the cycle after the low byte is sampled.
REQ-020 Internal column counter SHALL start at 0 per line and increment by 1 per completed pixel, saturating at SCREEN_WIDTH.
REQ-021 W_EN SHALL be asserted only when column < SCREEN_WIDTH and row < SCREEN_HEIGHT; other pixels are converted but not written.
REQ-022 CAM_HREF falling (high previous cycle, low now) in BYTE_LO or BYTE_HI: discard any unpaired high byte, reset column to 0, increment row (saturate at SCREEN_HEIGHT), go to WAIT_LINE.
REQ-023 CAM_VSYNC high in any state other than WAIT_FRAME: abort pixel in progress (no W_EN), reset row and column to 0, go to WAIT_FRAME.
REQ-024 FRAME_DONE SHALL pulse one cycle on the CAM_VSYNC rising edge only if at least one line completed since the previous frame start.
REQ-025 CAM_VSYNC has priority over CAM_HREF when both change in the same cycle.
REQ-026 X_ADDR/Y_ADDR SHALL hold their last written values while W_EN is low.

Reset
REQ-027 RESET_NEG low SHALL immediately force state WAIT_FRAME, row = column = 0, PIXEL_OUT = 8'h00, W_EN = 0, X_ADDR = 0, Y_ADDR = 0, FRAME_DONE = 0.
REQ-028 After RESET_NEG deasserts, no write SHALL occur until CAM_VSYNC has been observed low and a new CAM_HREF high begins; a line in progress at reset release is skipped.

Verification
REQ-029 Single pixel: VSYNC low, HREF high, bytes 8'hF8, 8'h1F -> one cycle later W_EN=1, PIXEL_OUT=8'hE3, X_ADDR=0, Y_ADDR=0.
REQ-030 Full frame: 144 lines x 352 bytes of 8'hFF -> 25344 W_EN pulses, all PIXEL_OUT=8'hFF, last write X=175 Y=143, then FRAME_DONE one pulse on VSYNC rise.
REQ-031 Overlong line: 360 bytes on one HREF -> exactly 176 writes; next line starts at X_ADDR=0, Y_ADDR=1.
REQ-032 Odd line: 5 bytes then HREF low -> 2 writes (X=0,1); fifth byte discarded; next line writes Y_ADDR=1, X_ADDR=0.
REQ-033 VSYNC mid-line: VSYNC rises after high byte of pixel 10 -> no write for pixel 10, FRAME_DONE pulse, next frame first write X=0 Y=0.
REQ-034 Reset mid-line: RESET_NEG low for 2 cycles during line 3 -> outputs go to reset values asynchronously; no writes until next VSYNC low and HREF rise, first write X=0 Y=0.
